// File: rtl/jesd204_tx_64b_pkg.sv
// Shared definitions for the JESD204C 64b/66b transmit lane sequencer:
// FSM encodings, sync-header codes and sync-word bit positions.
package jesd204_tx_64b_pkg;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StWaitLemc = 2'd1,
      StData     = 2'd2
   } state_e;

   localparam logic [1:0] SH_DATA0 = 2'b01;
   localparam logic [1:0] SH_DATA1 = 2'b10;

   // Sync-word layout within a 32-block multiblock
   localparam logic [4:0] EoembIdx   = 5'd26;
   localparam logic [4:0] PilotFirst = 5'd27;
   localparam logic [4:0] PilotLast  = 5'd31;

   localparam logic [57:0] ScrSeed = {1'b1, 57'b0};

   function automatic logic [1:0] sh_encode(input logic sh_bit);
      return sh_bit ? SH_DATA1 : SH_DATA0;
   endfunction

endpackage

// File: rtl/jesd204_scrambler_64b.sv
// Self-synchronous 64-bit scrambler/descrambler, polynomial 1 + x^39 + x^58.
// Bit 0 of each word is the earliest in time; state[57] holds the most recent bit.
module jesd204_scrambler_64b
   import jesd204_tx_64b_pkg::*;
#(
   parameter bit DESCRAMBLE = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic [63:0] i_data,
   output logic [63:0] o_data
);

   logic [57:0] r_state;
   logic [57:0] w_state_nxt;
   logic [63:0] w_scr;

   always_comb begin
      logic [121:0] v_hist;
      v_hist = {64'b0, r_state};
      w_scr  = '0;
      // v_hist[58+i] is bit i of this word; taps sit 39 and 58 bits earlier
      for (int i = 0; i < 64; i++) begin
         w_scr[i]      = i_data[i] ^ v_hist[i + 19] ^ v_hist[i];
         v_hist[58 + i] = DESCRAMBLE ? i_data[i] : w_scr[i];
      end
      w_state_nxt = v_hist[121:64];
   end

   assign o_data = i_enable ? w_scr : i_data;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ScrSeed;
      end else if (i_enable) begin
         r_state <= w_state_nxt;
      end
   end

endmodule

// File: rtl/jesd204_tx_64b_lane_sequencer.sv
// Per-lane JESD204C 64b/66b transmit sequencer: LEMC alignment, sync-header
// stream generation and scrambled block registration toward the PHY.
module jesd204_tx_64b_lane_sequencer
   import jesd204_tx_64b_pkg::*;
#(
   parameter int unsigned DATA_PATH_WIDTH = 64
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_cfg_link_enable,
   input  logic                       i_cfg_scrambling_disable,
   input  logic [7:0]                 i_cfg_emb_len_m1,
   input  logic                       i_lemc_edge,
   input  logic [25:0]                i_sh_payload,
   input  logic [DATA_PATH_WIDTH-1:0] i_tx_data,
   output logic                       o_tx_ready,
   output logic [DATA_PATH_WIDTH-1:0] o_phy_data,
   output logic [1:0]                 o_phy_header,
   output logic                       o_eomb,
   output logic                       o_eoemb,
   output logic [1:0]                 o_status_state,
   output logic                       o_status_misalign
);

   state_e                     r_state;
   logic [4:0]                 r_blk_cnt;
   logic [7:0]                 r_mb_cnt;
   logic [25:0]                r_payload;
   logic [7:0]                 r_emb_len_m1;
   logic                       r_misalign;
   logic [DATA_PATH_WIDTH-1:0] r_phy_data;
   logic [1:0]                 r_phy_header;
   logic                       r_eomb;
   logic                       r_eoemb;

   logic                       w_in_data;
   logic                       w_start;
   logic                       w_active;
   logic                       w_realign;
   logic [4:0]                 w_blk;
   logic [7:0]                 w_mb;
   logic [25:0]                w_payload;
   logic [7:0]                 w_emb_len;
   logic                       w_last_mb;
   logic                       w_sh_bit;
   logic [4:0]                 w_blk_nxt;
   logic [7:0]                 w_mb_nxt;
   logic                       w_scr_reset;
   logic                       w_scr_enable;
   logic [DATA_PATH_WIDTH-1:0] w_scr_data;

   always_comb begin
      w_in_data = (r_state == StData) && i_cfg_link_enable;
      w_start   = (r_state == StWaitLemc) && i_cfg_link_enable && i_lemc_edge;
      w_active  = w_in_data || w_start;
      w_realign = w_in_data && i_lemc_edge && ((r_blk_cnt != '0) || (r_mb_cnt != '0));

      // Index of the block being emitted this cycle, after any LEMC realignment
      w_blk     = (w_start || w_realign) ? '0 : r_blk_cnt;
      w_mb      = (w_start || w_realign) ? '0 : r_mb_cnt;
      w_payload = (w_blk == '0) ? i_sh_payload : r_payload;
      w_emb_len = ((w_blk == '0) && (w_mb == '0)) ? i_cfg_emb_len_m1 : r_emb_len_m1;
      w_last_mb = (w_mb == w_emb_len);

      if (w_blk < EoembIdx) begin
         w_sh_bit = w_payload[w_blk];
      end else if (w_blk == EoembIdx) begin
         w_sh_bit = w_last_mb;
      end else begin
         w_sh_bit = (w_blk == PilotLast);
      end

      w_blk_nxt = w_blk + 5'd1;
      if (w_blk == PilotLast) begin
         w_mb_nxt = w_last_mb ? 8'd0 : w_mb + 8'd1;
      end else begin
         w_mb_nxt = w_mb;
      end

      w_scr_reset  = i_reset || (r_state == StIdle);
      w_scr_enable = w_active && !i_cfg_scrambling_disable;
   end

   jesd204_scrambler_64b #(
      .DESCRAMBLE (1'b0)
   ) u_scrambler (
      .i_clk    (i_clk),
      .i_reset  (w_scr_reset),
      .i_enable (w_scr_enable),
      .i_data   (i_tx_data),
      .o_data   (w_scr_data)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_blk_cnt    <= '0;
         r_mb_cnt     <= '0;
         r_payload    <= '0;
         r_emb_len_m1 <= '0;
         r_misalign   <= 1'b0;
         r_phy_data   <= '0;
         r_phy_header <= SH_DATA0;
         r_eomb       <= 1'b0;
         r_eoemb      <= 1'b0;
      end else begin
         r_phy_data   <= w_active ? w_scr_data : '0;
         r_phy_header <= w_active ? sh_encode(w_sh_bit) : SH_DATA0;
         r_eomb       <= w_active && (w_blk == PilotLast);
         r_eoemb      <= w_active && (w_blk == PilotLast) && w_last_mb;
         if (w_active) begin
            r_payload    <= w_payload;
            r_emb_len_m1 <= w_emb_len;
         end

         if (!i_cfg_link_enable) begin
            r_state    <= StIdle;
            r_blk_cnt  <= '0;
            r_mb_cnt   <= '0;
            r_misalign <= 1'b0;
         end else begin
            if (w_realign) begin
               r_misalign <= 1'b1;
            end
            unique case (r_state)
               StIdle: begin
                  r_state   <= StWaitLemc;
                  r_blk_cnt <= '0;
                  r_mb_cnt  <= '0;
               end
               StWaitLemc: begin
                  if (i_lemc_edge) begin
                     r_state   <= StData;
                     r_blk_cnt <= w_blk_nxt;
                     r_mb_cnt  <= w_mb_nxt;
                  end
               end
               StData: begin
                  r_blk_cnt <= w_blk_nxt;
                  r_mb_cnt  <= w_mb_nxt;
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign o_tx_ready        = w_active;
   assign o_phy_data        = r_phy_data;
   assign o_phy_header      = r_phy_header;
   assign o_eomb            = r_eomb;
   assign o_eoemb           = r_eoemb;
   assign o_status_state    = r_state;
   assign o_status_misalign = r_misalign;

endmodule
